gpr_write_arbiter: RTL

Shares the single GPR write port between two sources. The first is the in-order pipeline writeback stream, which carries the ALU, memory, shift or link result already selected by the writeback stage. The second is the long-latency multiply/divide unit's result stream. The block sits between the writeback stage and the register file. It buffers muldiv results in a small FIFO and registers the winning write. A starvation counter forces a one-cycle pipeline stall so that buffered results always drain.

---
 rtl/gpr_write_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/gpr_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gpr_write_arbiter
// Brief    : Shares the single GPR write port between the in-order writeback
//            stream and the multiply/divide result stream. Muldiv results are
//            buffered in a small FIFO; a starvation counter forces a one-cycle
//            pipeline stall so buffered results always drain. The winning
//            write is registered toward the register file.
// Options  : WB_ARB_WAW_KILL_EN - when defined, an accepted pipeline write
//            clears the valid bit of any buffered (or same-cycle pushed)
//            muldiv entry with the same destination register.
// Revision : 1.0 - initial release
// ============================================================================
module gpr_write_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wb_we,
    input  logic [4:0]                    wb_addr,
    input  logic [31:0]                   wb_data,
    output logic                          wb_stall,
    input  logic                          md_valid,
    output logic                          md_ready,
    input  logic [4:0]                    md_addr,
    input  logic [31:0]                   md_data,
    output logic                          gpr_we,
    output logic [4:0]                    gpr_addr,
    output logic [31:0]                   gpr_data,
    output logic [$clog2(FIFO_DEPTH):0]   md_pending
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_t;

    // Control state
    state_t                 state_q, state_d;
    logic [3:0]             starve_q, starve_d;

    // FIFO storage; pointers carry one extra wrap bit for full/empty
    logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
    logic [FIFO_DEPTH-1:0]  ent_valid_q, ent_valid_d;
    logic [4:0]             ent_addr_q [FIFO_DEPTH];
    logic [31:0]            ent_data_q [FIFO_DEPTH];

    // Registered write port
    logic                   gpr_we_q, gpr_we_d;
    logic [4:0]             gpr_addr_q, gpr_addr_d;
    logic [31:0]            gpr_data_q, gpr_data_d;

    logic [PTR_W-1:0]       w_count;
    logic                   w_empty;
    logic                   w_full;
    logic [IDX_W-1:0]       w_rd_idx;
    logic [IDX_W-1:0]       w_wr_idx;
    logic                   w_head_valid;
    logic                   w_head_write;
    logic                   w_wbq;
    logic                   w_push;
    logic                   w_push_valid;
    logic                   w_pop;

    assign w_count      = wr_ptr_q - rd_ptr_q;
    assign w_empty      = (w_count == '0);
    assign w_full       = (w_count == PTR_W'(FIFO_DEPTH));
    assign w_rd_idx     = rd_ptr_q[IDX_W-1:0];
    assign w_wr_idx     = wr_ptr_q[IDX_W-1:0];
    assign w_head_valid = ~w_empty & ent_valid_q[w_rd_idx];
    // Entries targeting $0 are retired without using the port
    assign w_head_write = w_head_valid & (ent_addr_q[w_rd_idx] != 5'd0);

    // Stall depends on the state register only, never on an input
    assign wb_stall   = (state_q == ST_FORCE);
    assign w_wbq      = wb_we & (wb_addr != 5'd0) & ~wb_stall;
    // Space is judged from registered occupancy; a same-cycle pop does not help
    assign md_ready   = ~w_full;
    assign w_push     = md_valid & ~w_full;
    assign md_pending = w_count;

    assign gpr_we   = gpr_we_q;
    assign gpr_addr = gpr_addr_q;
    assign gpr_data = gpr_data_q;

    // Port arbitration: pipeline first in NORMAL, FIFO head in FORCE or when idle
    always_comb begin
        w_pop      = 1'b0;
        gpr_we_d   = 1'b0;
        gpr_addr_d = gpr_addr_q;
        gpr_data_d = gpr_data_q;
        if (state_q == ST_FORCE) begin
            w_pop = ~w_empty;
            if (w_head_write) begin
                gpr_we_d   = 1'b1;
                gpr_addr_d = ent_addr_q[w_rd_idx];
                gpr_data_d = ent_data_q[w_rd_idx];
            end
        end else if (w_wbq) begin
            gpr_we_d   = 1'b1;
            gpr_addr_d = wb_addr;
            gpr_data_d = wb_data;
            // A killed head does not need the port and is discarded meanwhile
            w_pop      = ~w_empty & ~ent_valid_q[w_rd_idx];
        end else if (~w_empty) begin
            w_pop = 1'b1;
            if (w_head_write) begin
                gpr_we_d   = 1'b1;
                gpr_addr_d = ent_addr_q[w_rd_idx];
                gpr_data_d = ent_data_q[w_rd_idx];
            end
        end
    end

    // Starvation tracking and NORMAL/FORCE sequencing
    always_comb begin
        starve_d = starve_q;
        state_d  = state_q;
        if (state_q == ST_FORCE) begin
            starve_d = 4'd0;
            state_d  = ST_NORMAL;
        end else begin
            if (w_pop || w_empty) begin
                starve_d = 4'd0;
            end else if (w_wbq && w_head_valid) begin
                starve_d = starve_q + 4'd1;
            end
            if (starve_d == 4'(STARVE_LIMIT)) begin
                state_d = ST_FORCE;
            end
        end
    end

    // Next valid bits: optional write-after-write kill, then the pushed entry
    always_comb begin
        ent_valid_d = ent_valid_q;
`ifdef WB_ARB_WAW_KILL_EN
        // The younger pipeline write supersedes any older muldiv result
        if (w_wbq) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (ent_addr_q[i] == wb_addr) begin
                    ent_valid_d[i] = 1'b0;
                end
            end
        end
        w_push_valid = ~(w_wbq && (md_addr == wb_addr));
`else
        w_push_valid = 1'b1;
`endif
        if (w_push) begin
            ent_valid_d[w_wr_idx] = w_push_valid;
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_NORMAL;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // FIFO pointers and valid bits; reset flushes all buffered entries
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            ent_valid_q <= '0;
        end else begin
            ent_valid_q <= ent_valid_d;
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // FIFO payload storage; contents are qualified by the valid bits and pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            ent_addr_q[w_wr_idx] <= md_addr;
            ent_data_q[w_wr_idx] <= md_data;
        end
    end

    // Registered write port toward the register file
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpr_we_q   <= 1'b0;
            gpr_addr_q <= 5'd0;
            gpr_data_q <= 32'd0;
        end else begin
            gpr_we_q   <= gpr_we_d;
            gpr_addr_q <= gpr_addr_d;
            gpr_data_q <= gpr_data_d;
        end
    end

endmodule
`default_nettype wire
